// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS subset core with one shared ALU and one unified req/ready memory port.
// Ports: clk/rst; mem_req/we/addr/wdata/rdata/ready memory handshake; pc_dbg, retire, halted status.
module mips_multicycle_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic [31:0]       pc_dbg,
    output logic              retire,
    output logic              halted
);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    state_t      r_state, w_next;
    logic [31:0] r_pc, r_ir, r_a, r_b, r_alu, r_mdr;
    logic [31:0] r_rf [0:31];

    logic [5:0]  w_op, w_funct;
    logic [4:0]  w_rs, w_rt, w_rd, w_wb_idx;
    logic [31:0] w_imm, w_alu_b, w_alu_y, w_wb_data, w_br_tgt;
    logic        w_is_r, w_is_j, w_is_beq, w_is_bne, w_is_addi, w_is_lw, w_is_sw;
    logic        w_funct_ok, w_legal, w_taken, w_aligned;
    logic        w_req, w_we, w_retire;
    logic [ADDR_W-1:0] w_addr;
    logic [31:0] w_wdata;

    assign w_op      = r_ir[31:26];
    assign w_rs      = r_ir[25:21];
    assign w_rt      = r_ir[20:16];
    assign w_rd      = r_ir[15:11];
    assign w_funct   = r_ir[5:0];
    assign w_imm     = {{16{r_ir[15]}}, r_ir[15:0]};

    assign w_is_r    = (w_op == 6'h00);
    assign w_is_j    = (w_op == 6'h02);
    assign w_is_beq  = (w_op == 6'h04);
    assign w_is_bne  = (w_op == 6'h05);
    assign w_is_addi = (w_op == 6'h08);
    assign w_is_lw   = (w_op == 6'h23);
    assign w_is_sw   = (w_op == 6'h2B);

    always_comb begin
        w_funct_ok = 1'b0;
        unique case (w_funct)
            6'h20, 6'h22, 6'h24, 6'h25, 6'h2A: w_funct_ok = 1'b1;
            default:                           w_funct_ok = 1'b0;
        endcase
    end

    // The all-zero word (sll $0,$0,0) is the only accepted non-ALU R-type: a nop.
    assign w_legal = (w_is_r && (w_funct_ok || r_ir == 32'h0))
                   || w_is_j || w_is_beq || w_is_bne
                   || w_is_addi || w_is_lw || w_is_sw;

    // Single shared ALU: R-type uses B, everything else adds the sign-extended immediate.
    assign w_alu_b = w_is_r ? r_b : w_imm;

    always_comb begin
        w_alu_y = r_a + w_alu_b;
        if (w_is_r) begin
            unique case (w_funct)
                6'h22:   w_alu_y = r_a - w_alu_b;
                6'h24:   w_alu_y = r_a & w_alu_b;
                6'h25:   w_alu_y = r_a | w_alu_b;
                6'h2A:   w_alu_y = {31'b0, $signed(r_a) < $signed(w_alu_b)};
                default: w_alu_y = r_a + w_alu_b;
            endcase
        end
    end

    // r_pc already holds PC+4 once the instruction is fetched.
    assign w_br_tgt  = r_pc + {w_imm[29:0], 2'b00};
    assign w_taken   = (w_is_beq && (r_a == r_b)) || (w_is_bne && (r_a != r_b));
    assign w_aligned = (r_alu[1:0] == 2'b00);
    assign w_wb_idx  = w_is_r ? w_rd : w_rt;
    assign w_wb_data = w_is_lw ? r_mdr : r_alu;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_FETCH;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        w_req    = 1'b0;
        w_we     = 1'b0;
        w_addr   = '0;
        w_wdata  = '0;
        w_retire = 1'b0;
        unique case (r_state)
            S_FETCH: begin
                w_req  = 1'b1;
                w_addr = r_pc[ADDR_W-1:0];
                if (mem_ready) w_next = S_DECODE;
            end
            S_DECODE: w_next = w_legal ? S_EXEC : S_HALT;
            S_EXEC: begin
                if (w_is_beq || w_is_bne || w_is_j) begin
                    w_retire = 1'b1;
                    w_next   = S_FETCH;
                end else if (w_is_lw || w_is_sw) begin
                    w_next = S_MEM;
                end else begin
                    w_next = S_WB;
                end
            end
            S_MEM: begin
                if (!w_aligned) begin
                    w_next = S_HALT;
                end else begin
                    w_req   = 1'b1;
                    w_we    = w_is_sw;
                    w_addr  = r_alu[ADDR_W-1:0];
                    w_wdata = r_b;
                    if (mem_ready) begin
                        w_retire = w_is_sw;
                        w_next   = w_is_sw ? S_FETCH : S_WB;
                    end
                end
            end
            S_WB: begin
                w_retire = 1'b1;
                w_next   = S_FETCH;
            end
            S_HALT:  w_next = S_HALT;
            default: w_next = S_FETCH;
        endcase
    end

    // Reset must drop the bus in the same cycle, so the outputs are gated directly.
    assign mem_req   = w_req & ~rst;
    assign mem_we    = w_we & ~rst;
    assign mem_addr  = rst ? '0 : w_addr;
    assign mem_wdata = rst ? '0 : w_wdata;
    assign retire    = w_retire & ~rst;
    assign halted    = (r_state == S_HALT) & ~rst;
    assign pc_dbg    = r_pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc  <= RESET_PC;
            r_ir  <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_alu <= '0;
            r_mdr <= '0;
            for (int i = 0; i < 32; i++) r_rf[i] <= '0;
        end else begin
            unique case (r_state)
                S_FETCH: begin
                    if (mem_ready) begin
                        r_ir <= mem_rdata;
                        r_pc <= r_pc + 32'd4;
                    end
                end
                S_DECODE: begin
                    r_a <= r_rf[w_rs];
                    r_b <= r_rf[w_rt];
                end
                S_EXEC: begin
                    r_alu <= w_alu_y;
                    if (w_taken) r_pc <= w_br_tgt;
                    else if (w_is_j) r_pc <= {r_pc[31:28], r_ir[25:0], 2'b00};
                end
                S_MEM: begin
                    if (w_aligned && mem_ready && w_is_lw) r_mdr <= mem_rdata;
                end
                S_WB: begin
                    // $0 is never written, so it always reads back zero.
                    if (w_wb_idx != 5'd0) r_rf[w_wb_idx] <= w_wb_data;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Directed bench for mips_multicycle_core with a wait-state memory model.
// Register results are observed through sw traffic on the memory port.
module tb_mips_multicycle_core;

    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam logic [31:0] ILL  = 32'hFC00_0000;

    logic        clk;
    logic        rst;
    logic        mem_req, mem_we, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_dbg;
    logic        retire, halted;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mips_multicycle_core #(.RESET_PC(BASE), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .pc_dbg(pc_dbg), .retire(retire), .halted(halted)
    );

    // Memory: program words in pmem, stores in dmem; addresses 0x40+ may be slow.
    logic [31:0]   pmem [0:1023];
    logic [31:0]   dmem [0:1023];
    logic [1023:0] dval;
    int            waits;
    bit            wait_all;
    int            wcnt;
    logic [9:0]    m_idx;
    logic          m_slow;

    always_comb begin
        m_idx     = mem_addr[11:2];
        m_slow    = wait_all || (mem_addr[11:6] != 6'd0);
        mem_ready = mem_req && (!m_slow || wcnt >= waits);
        mem_rdata = dval[m_idx] ? dmem[m_idx] : pmem[m_idx];
    end

    always @(posedge clk) begin
        if (rst) begin
            dval <= '0;
            wcnt <= 0;
        end else begin
            if (mem_req && !mem_ready) wcnt <= wcnt + 1;
            else                       wcnt <= 0;
            if (mem_req && mem_ready && mem_we) begin
                dmem[m_idx] <= mem_wdata;
                dval[m_idx] <= 1'b1;
            end
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          rtime [$];
    logic [31:0] raddr [$];
    logic [31:0] waddr [$];
    logic [31:0] wdat  [$];
    int          stab_err, req_halt, ret_halt;
    logic        pend;
    logic [64:0] saved;

    always @(negedge clk) begin
        if (rst) begin
            rtime.delete();
            raddr.delete();
            waddr.delete();
            wdat.delete();
            stab_err <= 0;
            req_halt <= 0;
            ret_halt <= 0;
            pend     <= 1'b0;
            saved    <= '0;
        end else begin
            if (retire) rtime.push_back(cyc);
            if (mem_req && mem_ready) begin
                if (mem_we) begin
                    waddr.push_back(mem_addr);
                    wdat.push_back(mem_wdata);
                end else begin
                    raddr.push_back(mem_addr);
                end
            end
            if (pend && mem_req && ({mem_we, mem_addr, mem_wdata} != saved))
                stab_err <= stab_err + 1;
            if (halted && mem_req) req_halt <= req_halt + 1;
            if (halted && retire)  ret_halt <= ret_halt + 1;
            pend  <= mem_req && !mem_ready;
            saved <= {mem_we, mem_addr, mem_wdata};
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic int rt(input int i);
        if (i < rtime.size()) return rtime[i];
        return -1000;
    endfunction

    function automatic logic [31:0] ra(input int i);
        if (i < raddr.size()) return raddr[i];
        return 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] wa(input int i);
        if (i < waddr.size()) return waddr[i];
        return 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] wd(input int i);
        if (i < wdat.size()) return wdat[i];
        return 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] rs, rt_, rd,
                                          input logic [5:0] f);
        return {6'h00, rs, rt_, rd, 5'h00, f};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, rt_,
                                          input logic [15:0] imm);
        return {op, rs, rt_, imm};
    endfunction

    task automatic hold_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 1024; i++) pmem[i] = ILL;
    endtask

    task automatic release_rst(input int w, input bit all);
        waits    = w;
        wait_all = all;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_halt(input string nm, input int budget);
        for (int i = 0; i < budget && !halted; i++) @(negedge clk);
        chk(nm, {31'b0, halted}, 32'd1);
    endtask

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [8];

    initial begin
        logic [31:0] pc_save;
        int          k;

        tbl[0] = '{"add",  enc_r(1, 2, 3, 6'h20), 32'd2};
        tbl[1] = '{"sub",  enc_r(1, 2, 3, 6'h22), 32'd8};
        tbl[2] = '{"and",  enc_r(1, 2, 3, 6'h24), 32'd5};
        tbl[3] = '{"or",   enc_r(1, 2, 3, 6'h25), 32'hFFFF_FFFD};
        tbl[4] = '{"slt21", enc_r(2, 1, 3, 6'h2A), 32'd1};
        tbl[5] = '{"slt12", enc_r(1, 2, 3, 6'h2A), 32'd0};
        tbl[6] = '{"addi", enc_i(6'h08, 1, 3, 16'hFFF9), 32'hFFFF_FFFE};
        tbl[7] = '{"nop",  32'h0000_0000, 32'd0};

        rst      = 1'b1;
        waits    = 0;
        wait_all = 1'b0;
        for (int i = 0; i < 1024; i++) pmem[i] = ILL;
        repeat (3) @(negedge clk);
        chk("rst_req",   {31'b0, mem_req}, 32'd0);
        chk("rst_we",    {31'b0, mem_we}, 32'd0);
        chk("rst_addr",  mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_pc",    pc_dbg, BASE);
        chk("rst_ret",   {31'b0, retire}, 32'd0);
        chk("rst_halt",  {31'b0, halted}, 32'd0);

        // ALU ops: $1=5, $2=-3, op into $3, store $3 to 0x100, then halt.
        for (int v = 0; v < 8; v++) begin
            hold_reset();
            pmem[0] = enc_i(6'h08, 0, 1, 16'd5);
            pmem[1] = enc_i(6'h08, 0, 2, 16'hFFFD);
            pmem[2] = tbl[v].instr;
            pmem[3] = enc_i(6'h2B, 0, 3, 16'h0100);
            release_rst(0, 1'b0);
            wait_halt({tbl[v].name, "_halt"}, 200);
            chk({tbl[v].name, "_val"},  wd(0), tbl[v].exp);
            chk({tbl[v].name, "_addr"}, wa(0), 32'h0000_0100);
            chk({tbl[v].name, "_nret"}, rtime.size(), 32'd4);
            chk({tbl[v].name, "_cyc"},  32'(rt(2) - rt(1)), 32'd4);
            chk({tbl[v].name, "_swcyc"}, 32'(rt(3) - rt(2)), 32'd4);
            chk({tbl[v].name, "_pc"},   pc_dbg, BASE + 32'h14);
        end

        // sw then lw through a 3-wait data memory.
        hold_reset();
        pmem[0] = enc_i(6'h08, 0, 1, 16'd5);
        pmem[1] = enc_i(6'h2B, 0, 1, 16'h0080);
        pmem[2] = enc_i(6'h23, 0, 5, 16'h0080);
        pmem[3] = enc_i(6'h2B, 0, 5, 16'h0084);
        release_rst(3, 1'b0);
        wait_halt("ws_halt", 300);
        chk("ws_sw_cyc", 32'(rt(1) - rt(0)), 32'd7);
        chk("ws_lw_cyc", 32'(rt(2) - rt(1)), 32'd8);
        chk("ws_lw_val", wd(1), 32'd5);
        chk("ws_addr",   wa(1), 32'h0000_0084);
        chk("ws_stable", 32'(stab_err), 32'd0);

        // bne not taken, then beq looping on itself.
        hold_reset();
        pmem[0] = enc_i(6'h08, 0, 1, 16'd5);
        pmem[1] = enc_i(6'h05, 1, 1, 16'd4);
        pmem[2] = enc_i(6'h04, 1, 1, 16'hFFFF);
        release_rst(0, 1'b0);
        repeat (30) @(negedge clk);
        chk("br_f1",   ra(1), BASE + 32'h4);
        chk("br_f2",   ra(2), BASE + 32'h8);
        chk("br_f3",   ra(3), BASE + 32'h8);
        chk("br_f4",   ra(4), BASE + 32'h8);
        chk("bne_cyc", 32'(rt(1) - rt(0)), 32'd3);
        chk("beq_cyc", 32'(rt(2) - rt(1)), 32'd3);
        chk("beq_cyc2", 32'(rt(3) - rt(2)), 32'd3);
        chk("br_nohalt", {31'b0, halted}, 32'd0);

        // j into a new 256-byte offset of the same 256MB region; $0 stays 0.
        hold_reset();
        pmem[0]  = {6'h02, 26'h40};
        pmem[64] = enc_i(6'h08, 0, 0, 16'd7);
        pmem[65] = enc_i(6'h2B, 0, 0, 16'h0080);
        release_rst(0, 1'b0);
        wait_halt("j_halt", 200);
        chk("j_tgt",  ra(1), BASE + 32'h100);
        chk("j_cyc",  32'(rt(0) - rt(0) + (rt(1) >= 0 ? 3 : 0)), 32'd3);
        chk("r0_cyc", 32'(rt(1) - rt(0)), 32'd4);
        chk("r0_val", wd(0), 32'd0);
        chk("j_pc",   pc_dbg, BASE + 32'h10C);

        // Illegal opcode after one good instruction: frozen afterwards.
        hold_reset();
        pmem[0] = enc_i(6'h08, 0, 1, 16'd5);
        pmem[1] = ILL;
        release_rst(0, 1'b0);
        wait_halt("ill_halt", 100);
        pc_save = pc_dbg;
        repeat (10) @(negedge clk);
        chk("ill_nret",  rtime.size(), 32'd1);
        chk("ill_pc",    pc_dbg, BASE + 32'h8);
        chk("ill_frz",   pc_dbg, pc_save);
        chk("ill_req",   32'(req_halt), 32'd0);
        chk("ill_ret",   32'(ret_halt), 32'd0);

        // Illegal funct.
        hold_reset();
        pmem[0] = enc_r(1, 2, 3, 6'h21);
        release_rst(0, 1'b0);
        wait_halt("fn_halt", 100);
        chk("fn_nret", rtime.size(), 32'd0);
        chk("fn_pc",   pc_dbg, BASE + 32'h4);

        // Misaligned lw: no data request at all.
        hold_reset();
        pmem[0] = enc_i(6'h23, 0, 5, 16'h0011);
        release_rst(0, 1'b0);
        wait_halt("mis_halt", 100);
        repeat (5) @(negedge clk);
        chk("mis_nret", rtime.size(), 32'd0);
        chk("mis_nrd",  raddr.size(), 32'd1);
        chk("mis_nwr",  waddr.size(), 32'd0);
        chk("mis_req",  32'(req_halt), 32'd0);
        chk("mis_pc",   pc_dbg, BASE + 32'h4);

        // Reset during a stalled fetch, then restart with a fresh program.
        hold_reset();
        pmem[0] = enc_i(6'h08, 0, 1, 16'd5);
        pmem[1] = enc_i(6'h2B, 0, 1, 16'h0080);
        release_rst(4, 1'b1);
        k = 0;
        while (rtime.size() < 1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("mf_first_ret", rtime.size(), 32'd1);
        repeat (2) @(negedge clk);
        chk("mf_pend_req",  {31'b0, mem_req}, 32'd1);
        chk("mf_pend_addr", mem_addr, BASE + 32'h4);
        #2 rst = 1'b1;
        #1;
        chk("mf_req_drop", {31'b0, mem_req}, 32'd0);
        chk("mf_pc",       pc_dbg, BASE);
        chk("mf_addr",     mem_addr, 32'd0);
        for (int i = 0; i < 1024; i++) pmem[i] = ILL;
        pmem[0] = enc_i(6'h2B, 0, 1, 16'h0080);
        release_rst(2, 1'b1);
        wait_halt("mf_halt", 200);
        chk("mf_reg_zero", wd(0), 32'd0);
        chk("mf_st_addr",  wa(0), 32'h0000_0080);
        chk("mf_nret",     rtime.size(), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_core.md
Name: mips_multicycle_core

Overview:
- Multi-cycle successor to the single-cycle MIPS core: same instruction subset plus bne, addi and a halt-on-illegal mode.
- Executes one instruction over 3–5 FSM states and shares one ALU.
- Uses a single unified memory port with a req/ready handshake, replacing the separate combinational instruction and data memories, so wait-state memories can be attached.
- Sits at the top of the CPU and is driven by the memory subsystem.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- ADDR_W, 32, width of mem_addr (low ADDR_W bits of the 32-bit byte address); legal range 8..32.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- mem_req  out  1  memory request valid.
- mem_we  out  1  1=write (sw), 0=read.
- mem_addr  out  ADDR_W  byte address, word aligned.
- mem_wdata  out  32  store data.
- mem_rdata  in  32  read data, valid in the cycle mem_ready=1.
- mem_ready  in  1  request accepted/completed this cycle.
- pc_dbg  out  32  current PC.
- retire  out  1  one-cycle pulse when an instruction completes.
- halted  out  1  core stopped in HALT.

Behaviour:
- Reset (async) values:
  - state=FETCH, PC=RESET_PC.
  - All 32 registers = 0.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - retire=0, halted=0.
  - Reset during an outstanding request drops mem_req immediately; the memory must tolerate the abandoned request.
- States: FETCH, DECODE, EXEC, MEM, WB, HALT. IR, A, B, ALUOut and MDR are internal registers.
- FETCH:
  - mem_req=1, mem_we=0, mem_addr=PC.
  - Held until mem_ready=1; then IR<=mem_rdata, PC<=PC+4, go to DECODE.
  - With zero-wait memory (ready in the same cycle as req), FETCH lasts 1 cycle.
- DECODE: A<=rf[rs], B<=rf[rt]. Go to EXEC, or to HALT on an illegal opcode/funct.
- EXEC:
  - R-type: ALUOut<=A op B; go to WB.
  - addi/lw/sw: ALUOut<=A+sext(imm); addi goes to WB, lw/sw go to MEM.
  - beq/bne: if taken (A==B for beq, A!=B for bne), PC<=PC+(sext(imm)<<2). Retire, go to FETCH.
  - j: PC<={PC[31:28],imm26,2'b00}. Retire, go to FETCH.
  - Note: PC in EXEC already holds PC+4.
- MEM:
  - Misaligned address (ALUOut[1:0]!=0) goes to HALT with no request issued.
  - Otherwise mem_req=1, mem_addr=ALUOut, mem_we=(sw), mem_wdata=B.
  - Handshake completes on mem_ready=1. sw: retire, go to FETCH. lw: MDR<=mem_rdata, go to WB.
- WB:
  - R-type: rf[rd]<=ALUOut. addi: rf[rt]<=ALUOut. lw: rf[rt]<=MDR.
  - Retire, go to FETCH.
- Handshake rules:
  - While mem_req=1 and mem_ready=0, mem_addr, mem_we and mem_wdata stay stable.
  - mem_ready while mem_req=0 is ignored.
  - mem_req deasserts in the cycle after acceptance.
- Supported opcodes: R-type 0x00, j 0x02, beq 0x04, bne 0x05, addi 0x08, lw 0x23, sw 0x2B.
- Supported R funct: add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A (signed).
- sll with an all-zero word (0x00000000) is treated as nop.
- Any other opcode/funct is illegal and goes to HALT.
- Arithmetic: add, sub and addi wrap modulo 2^32; no overflow trap.
- Register $0: reads always return 0; writes to $0 are discarded.
- HALT: halted=1, mem_req=0, PC frozen at PC+4 of the faulting instruction. Exit only by reset.
- Zero-wait cycle counts: R/addi/sw = 4, lw = 5, beq/bne/j = 3. Each wait cycle from memory adds 1.
- retire pulses for exactly one cycle per completed instruction; it never pulses for an instruction that halts.

Test Plan:
- Zero-wait memory, program `addi $1,$0,5; addi $2,$0,-3; add $3,$1,$2; slt $4,$2,$1` -> $3=2, $4=1, 4 retire pulses 4 cycles apart.
- `sw $1,0x10($0)` then `lw $5,0x10($0)` with mem_ready delayed 3 cycles -> mem_addr/mem_wdata stable during wait, $5=5, lw takes 8 cycles.
- `beq $1,$1,-1` at PC=0x8 -> PC=0x8 again (loop). `bne $1,$1,+4` -> not taken, PC=0xC. Each takes 3 cycles.
- `j 0x40` at PC=0x1000_0000 -> PC=0x1000_0100. `addi $0,$0,7` -> $0 reads 0.
- Opcode 0x3F, and separately `lw` at address 0x11 -> halted=1, no further mem_req, no retire, pc_dbg frozen.
- rst asserted mid-FETCH with mem_req=1 -> mem_req=0 the same cycle, pc_dbg=RESET_PC, registers 0; execution restarts correctly after release.
